// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between the instruction-fetch
// requester (I) and the load/store requester (D). D has fixed priority, and a burst
// counter lets I through after MAX_DBURST consecutive D grants that it waited on.
// One transaction is in flight at a time; every transaction ends in a response pulse.
//
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_i_req/i_i_addr, o_i_ready          fetch request channel
//   o_i_valid/o_i_rdata                  fetch response channel
//   i_d_req/wen/addr/wdata/mask, o_d_ready  data request channel
//   o_d_valid/o_d_rdata                  data response / store ack channel
//   o_mem_req/addr/ren/wen/wdata/mask    registered memory request
//   i_mem_ready/valid/rdata              memory handshake and read data

package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  // Payload held on the memory port for the whole transaction
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
    logic              ren;
    logic              wen;
  } mem_cmd_t;

endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // fetch requester
  input  logic              i_i_req,
  input  logic [ADDR_W-1:0] i_i_addr,
  output logic              o_i_ready,
  output logic              o_i_valid,
  output logic [DATA_W-1:0] o_i_rdata,
  // load/store requester
  input  logic              i_d_req,
  input  logic              i_d_wen,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [MASK_W-1:0] i_d_mask,
  output logic              o_d_ready,
  output logic              o_d_valid,
  output logic [DATA_W-1:0] o_d_rdata,
  // memory port
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [MASK_W-1:0] o_mem_mask,
  input  logic              i_mem_ready,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DBURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             req_q,   req_d;
  mem_cmd_t         cmd_q,   cmd_d;

  logic i_win_c;
  logic d_win_c;
  logic resp_c;

  // Next-state, arbitration and response decode
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cmd_d   = cmd_q;
    i_win_c = 1'b0;
    d_win_c = 1'b0;
    resp_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // D wins unless fetch has waited through a full D burst
        d_win_c = i_d_req && !(i_i_req && (cnt_q == CNT_MAX));
        i_win_c = i_i_req && !d_win_c;

        if (d_win_c) begin
          cmd_d.addr  = i_d_addr;
          cmd_d.wdata = i_d_wdata;
          cmd_d.mask  = i_d_mask;
          cmd_d.ren   = ~i_d_wen;
          cmd_d.wen   = i_d_wen;
          req_d       = 1'b1;
          owner_d     = OWN_D;
          state_d     = ST_REQ;
          // Count only D grants that made a waiting fetch wait longer
          if (i_i_req) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end else if (i_win_c) begin
          cmd_d.addr  = i_i_addr;
          cmd_d.wdata = '0;
          cmd_d.mask  = '1;
          cmd_d.ren   = 1'b1;
          cmd_d.wen   = 1'b0;
          req_d       = 1'b1;
          owner_d     = OWN_I;
          state_d     = ST_REQ;
          cnt_d       = '0;
        end
      end

      ST_REQ: begin
        if (i_mem_ready) begin
          req_d     = 1'b0;
          cmd_d.ren = 1'b0;
          cmd_d.wen = 1'b0;
          // Memory may return the response in the accept cycle itself
          resp_c    = i_mem_valid;
          if (i_mem_valid) begin
            owner_d = OWN_NONE;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        resp_c = i_mem_valid;
        if (i_mem_valid) begin
          owner_d = OWN_NONE;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and memory-port registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
    end
  end

  assign o_i_ready   = i_win_c;
  assign o_d_ready   = d_win_c;

  assign o_i_valid   = resp_c && (owner_q == OWN_I);
  assign o_d_valid   = resp_c && (owner_q == OWN_D);
  assign o_i_rdata   = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;

  assign o_mem_req   = req_q;
  assign o_mem_addr  = cmd_q.addr;
  assign o_mem_ren   = cmd_q.ren;
  assign o_mem_wen   = cmd_q.wen;
  assign o_mem_wdata = cmd_q.wdata;
  assign o_mem_mask  = cmd_q.mask;

endmodule
